pcg_range_sampler: RTL and testbench

- Downstream consumer of the 64-bit PCG64-DXSM generator: turns raw 64-bit words into unbiased integers in [0, bound).
- Uses mask-and-reject sampling. Pulses the generator's enable only when it needs a fresh word, and serves each word as two W-bit candidates.
- Sits between the PRNG core and any requester (test-pattern, dither or shuffle logic) behind a valid/ready request/response pair.

---
 rtl/pcg_pkg.sv | 18 +
 rtl/pcg_mask_smear.sv | 25 ++
 rtl/pcg_range_sampler.sv | 145 ++++++++++++++
 tb/tb_pcg_range_sampler.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/pcg_pkg.sv
// Shared types and constants for the PCG64 range sampler.
// Holds the sampler state encoding and the layout of the 64-bit PRNG word.
package pcg_pkg;

   localparam int RNG_W    = 64;
   localparam int HALF_OFS = 32;

   typedef enum logic [2:0] {
      S_IDLE,
      S_MASK,
      S_FETCH,
      S_CAPT,
      S_LO,
      S_HI,
      S_DONE
   } state_t;

endpackage

// File: rtl/pcg_mask_smear.sv
// Combinational MSB-smear of (bound - 1): every bit at and below the top set bit is forced to 1.
// This gives the tightest power-of-two-minus-one mask that covers [0, bound).
module pcg_mask_smear #(
   parameter int W = 32
) (
   input  logic [W-1:0] bound,
   output logic [W-1:0] mask
);

   logic [W-1:0] limit;
   logic         seen;

   assign limit = bound - W'(1);

   // Walk from the MSB down; once a 1 is seen, every lower bit is set.
   always_comb begin
      mask = '0;
      seen = 1'b0;
      for (int i = W - 1; i >= 0; i--) begin
         seen    = seen | limit[i];
         mask[i] = seen;
      end
   end

endmodule

// File: rtl/pcg_range_sampler.sv
// Turns raw 64-bit PCG64-DXSM words into unbiased integers in [0, bound) by mask-and-reject.
// Each PRNG word yields two W-bit candidates (low half, then high half) before another word is fetched.
module pcg_range_sampler
   import pcg_pkg::*;
#(
   parameter int W         = 32,
   parameter int MAX_WORDS = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [W-1:0]     req_bound,
   output logic             rng_en,
   input  logic [RNG_W-1:0] rng_data,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [W-1:0]     res_data,
   output logic             res_err,
   output logic [4:0]       res_words,
   output state_t           dbg_state
);

   // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
   // req_ready is high only in IDLE; res_valid is high only in DONE, and the result is
   // held unchanged until res_ready is seen.

   localparam logic [4:0] MAX_CNT = 5'(MAX_WORDS);

   state_t           state;
   state_t           state_nxt;
   logic [W-1:0]     bound_q;
   logic [W-1:0]     mask_q;
   logic [2*W-1:0]   word_q;
   logic [4:0]       cnt;
   logic [W-1:0]     res_data_q;
   logic             res_err_q;
   logic [W-1:0]     smear_mask;
   logic [W-1:0]     lo_cand;
   logic [W-1:0]     hi_cand;
   logic             lo_hit;
   logic             hi_hit;
   logic             unused_rng_bits;

   pcg_mask_smear #(.W(W)) u_smear (
      .bound (bound_q),
      .mask  (smear_mask)
   );

   // Only the two W-bit candidate fields of the PRNG word are kept.
   assign unused_rng_bits = ^rng_data;

   assign lo_cand = word_q[W-1:0] & mask_q;
   assign hi_cand = word_q[2*W-1:W] & mask_q;
   assign lo_hit  = (lo_cand < bound_q);
   assign hi_hit  = (hi_cand < bound_q);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (req_valid) begin
               state_nxt = (req_bound <= W'(1)) ? S_DONE : S_MASK;
            end
         end
         S_MASK:  state_nxt = S_FETCH;
         S_FETCH: state_nxt = S_CAPT;
         S_CAPT:  state_nxt = S_LO;
         S_LO:    state_nxt = lo_hit ? S_DONE : S_HI;
         S_HI: begin
            if (hi_hit || (cnt == MAX_CNT)) begin
               state_nxt = S_DONE;
            end else begin
               state_nxt = S_FETCH;
            end
         end
         S_DONE: begin
            if (res_ready) begin
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bound_q    <= '0;
         mask_q     <= '0;
         word_q     <= '0;
         cnt        <= '0;
         res_data_q <= '0;
         res_err_q  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  bound_q    <= req_bound;
                  cnt        <= '0;
                  res_data_q <= '0;
                  res_err_q  <= (req_bound == '0);
               end
            end
            S_MASK: mask_q <= smear_mask;
            S_FETCH: begin
               if (cnt != MAX_CNT) begin
                  cnt <= cnt + 5'd1;
               end
            end
            S_CAPT: word_q <= {rng_data[HALF_OFS +: W], rng_data[W-1:0]};
            S_LO: begin
               if (lo_hit) begin
                  res_data_q <= lo_cand;
               end
            end
            S_HI: begin
               // res_data_q is already 0 from accept, so the retry-limit case only flags the error.
               if (hi_hit) begin
                  res_data_q <= hi_cand;
               end else if (cnt == MAX_CNT) begin
                  res_err_q <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign req_ready = (state == S_IDLE);
   assign rng_en    = (state == S_FETCH);
   assign res_valid = (state == S_DONE);
   assign res_data  = res_data_q;
   assign res_err   = res_err_q;
   assign res_words = cnt;
   assign dbg_state = state;

endmodule

// File: tb/tb_pcg_range_sampler.sv
// Randomized and directed bench for pcg_range_sampler against a plain-arithmetic reference model.
// The PRNG is replaced by a word queue presented the cycle after each rng_en pulse.
module tb_pcg_range_sampler;
   import pcg_pkg::*;

   localparam int W         = 8;
   localparam int MAX_WORDS = 2;

   logic          clk;
   logic          rst;
   logic          req_valid;
   logic          req_ready;
   logic [W-1:0]  req_bound;
   logic          rng_en;
   logic [63:0]   rng_data;
   logic          res_valid;
   logic          res_ready;
   logic [W-1:0]  res_data;
   logic          res_err;
   logic [4:0]    res_words;
   state_t        dbg_state;

   int            n_vec;
   int            n_err;
   int            en_count;
   logic [63:0]   words_q[$];

   logic [W-1:0]  obs_data;
   logic          obs_err;
   logic [4:0]    obs_words;

   pcg_range_sampler #(.W(W), .MAX_WORDS(MAX_WORDS)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_bound (req_bound),
      .rng_en    (rng_en),
      .rng_data  (rng_data),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_data  (res_data),
      .res_err   (res_err),
      .res_words (res_words),
      .dbg_state (dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // PRNG stand-in: on each enable pulse, present the next queued word for the following cycle.
   always @(negedge clk) begin
      if (rng_en) begin
         en_count = en_count + 1;
         if (words_q.size() > 0) rng_data = words_q.pop_front();
         else rng_data = {$urandom, $urandom};
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference: mask is (smallest power of two >= bound) - 1; try low then high half of each word.
   function automatic void ref_model(input logic [W-1:0] bound, output logic [W-1:0] d,
                                     output logic e, output int n, output int lat);
      longint unsigned p;
      longint unsigned m;
      longint unsigned lo;
      longint unsigned hi;
      d = '0; e = 1'b0; n = 0; lat = 1;
      if (bound == 0) begin
         e = 1'b1;
         return;
      end
      if (bound == 1) return;
      p = 1;
      while (p < longint'(bound)) p = p * 2;
      m = p - 1;
      for (int k = 0; k < MAX_WORDS; k++) begin
         lo = longint'(words_q[k][31:0]) % (longint'(1) << W) & m;
         hi = longint'(words_q[k][63:32]) % (longint'(1) << W) & m;
         if (lo < longint'(bound)) begin
            d = W'(lo); n = k + 1; lat = 4 * k + 5;
            return;
         end
         if (hi < longint'(bound)) begin
            d = W'(hi); n = k + 1; lat = 4 * k + 6;
            return;
         end
      end
      e = 1'b1; n = MAX_WORDS; lat = 4 * (MAX_WORDS - 1) + 6;
   endfunction

   task automatic run_req(input logic [W-1:0] bound, input int hold);
      logic [W-1:0] d_exp;
      logic         e_exp;
      int           n_exp;
      int           lat_exp;
      int           lat_seen;
      logic         stable;
      while (words_q.size() < MAX_WORDS) words_q.push_back({$urandom, $urandom});
      ref_model(bound, d_exp, e_exp, n_exp, lat_exp);
      en_count = 0;
      @(negedge clk);
      req_valid = 1'b1;
      req_bound = bound;
      check("req_ready_idle", 64'(req_ready), 64'd1);
      @(posedge clk);
      #1 req_valid = 1'b0;
      lat_seen = -1;
      for (int c = 1; c <= 200; c++) begin
         @(negedge clk);
         if (res_valid) begin
            lat_seen = c;
            break;
         end
      end
      check("latency", 64'(lat_seen), 64'(lat_exp));
      obs_data = res_data; obs_err = res_err; obs_words = res_words;
      check("res_data", 64'(res_data), 64'(d_exp));
      check("res_err", 64'(res_err), 64'(e_exp));
      check("res_words", 64'(res_words), 64'(n_exp));
      stable = 1'b1;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         if (!res_valid || rng_en || res_data !== obs_data || res_err !== obs_err ||
             res_words !== obs_words) stable = 1'b0;
      end
      if (hold > 0) check("hold_stable", 64'(stable), 64'd1);
      check("rng_pulses", 64'(en_count), 64'(n_exp));
      res_ready = 1'b1;
      @(posedge clk);
      #1 res_ready = 1'b0;
      @(negedge clk);
      check("back_idle", {62'd0, req_ready, res_valid}, 64'b10);
      words_q.delete();
   endtask

   task automatic reset_mid_hi();
      logic quiet;
      logic reached;
      words_q.push_back(64'h00000007_00000007);
      words_q.push_back(64'h00000003_00000003);
      @(negedge clk);
      req_valid = 1'b1;
      req_bound = 8'd6;
      @(posedge clk);
      #1 req_valid = 1'b0;
      reached = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (dbg_state == S_HI) begin
            reached = 1'b1;
            break;
         end
      end
      check("reach_hi", 64'(reached), 64'd1);
      rst = 1'b1;
      #1;
      check("rst_req_ready", 64'(req_ready), 64'd1);
      check("rst_outputs", {58'd0, rng_en, res_valid, res_err, res_words[2:0]}, 64'd0);
      check("rst_words", 64'(res_words), 64'd0);
      check("rst_data", 64'(res_data), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      quiet = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (res_valid || rng_en || !req_ready) quiet = 1'b0;
      end
      check("post_rst_quiet", 64'(quiet), 64'd1);
      words_q.delete();
   endtask

   initial begin
      n_vec = 0; n_err = 0; en_count = 0;
      rst = 1'b1; req_valid = 1'b0; req_bound = '0; res_ready = 1'b0; rng_data = '0;
      repeat (3) @(negedge clk);
      check("init_req_ready", 64'(req_ready), 64'd1);
      check("init_outputs", {56'd0, rng_en, res_valid, res_err, res_words}, 64'd0);
      check("init_data", 64'(res_data), 64'd0);
      rst = 1'b0;

      run_req(8'd1, 0);
      check("b1_data", 64'(obs_data), 64'd0);
      run_req(8'd0, 2);
      check("b0_err", {63'd0, obs_err}, 64'd1);

      words_q.push_back(64'h00000000_00000003);
      run_req(8'd6, 1);
      check("d1_data", 64'(obs_data), 64'd3);

      words_q.push_back(64'h00000002_00000007);
      run_req(8'd6, 0);
      check("d2_data", 64'(obs_data), 64'd2);

      words_q.push_back(64'h00000007_00000006);
      words_q.push_back(64'h00000000_00000005);
      run_req(8'd6, 0);
      check("d3_data", 64'(obs_data), 64'd5);
      check("d3_words", 64'(obs_words), 64'd2);

      words_q.push_back(64'hFFFFFFFF_FFFFFFFF);
      words_q.push_back(64'hFFFFFFFF_FFFFFFFF);
      run_req(8'd5, 10);
      check("exhaust_err", {63'd0, obs_err}, 64'd1);

      words_q.push_back(64'h00000000_000000FE);
      run_req(8'd255, 0);
      check("top_bound", 64'(obs_data), 64'd254);

      words_q.push_back(64'h00000012_000000FF);
      run_req(8'd255, 0);
      check("top_bound_hi", 64'(obs_data), 64'h12);

      reset_mid_hi();

      for (int t = 0; t < 40; t++) begin
         int r;
         logic [W-1:0] b;
         r = $urandom_range(0, 9);
         if (r == 0) b = 8'd0;
         else if (r == 1) b = 8'd1;
         else if (r == 2) b = 8'd255;
         else b = W'($urandom_range(2, 255));
         run_req(b, $urandom_range(0, 3));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
